// File: rtl/shape_phase_sched.sv
// shape_phase_sched
//   Time-multiplexing scheduler for the shared squarer/hit-test datapath of
//   the VGA shape renderer. It steps a phase index through NUM_PHASES operand
//   sets per pixel and ORs each phase's hit vector into an accumulator. Once
//   per pixel it emits the merged hit vector, registered, with a one-cycle
//   valid strobe.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous reset, active high
//   en         : advance enable; when low, all state holds
//   line_start : resynchronise to phase 0, drop the partial pixel, clear pix_cnt
//   display_on : active-video qualifier, sampled only on the emit edge
//   hit_in     : datapath hit bits for the phase held during this cycle
//   phase      : operand-set select to the squarer input muxes (registered)
//   hit_vec    : merged hits of the last completed pixel (registered, held)
//   hit_any    : OR-reduction of hit_vec (registered, held)
//   out_valid  : one-cycle strobe marking a new hit_vec / hit_any
//   pix_cnt    : pixels emitted since the last line_start, saturating
module shape_phase_sched #(
    parameter int NUM_PHASES = 2,
    parameter int HIT_W      = 21,
    parameter int CNT_W      = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          line_start,
    input  logic                          display_on,
    input  logic [HIT_W-1:0]              hit_in,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [HIT_W-1:0]              hit_vec,
    output logic                          hit_any,
    output logic                          out_valid,
    output logic [CNT_W-1:0]              pix_cnt
);

    localparam int              PH_W    = $clog2(NUM_PHASES);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

    logic [HIT_W-1:0] acc;
    logic [HIT_W-1:0] merged;
    logic             last_ph;

    assign last_ph = (phase == LAST_PH);
    assign merged  = acc | hit_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            acc       <= '0;
            hit_vec   <= '0;
            hit_any   <= 1'b0;
            out_valid <= 1'b0;
            pix_cnt   <= '0;
        end else if (line_start) begin
            // Partial pixel is dropped; hit_vec/hit_any keep the last emit.
            phase     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            pix_cnt   <= '0;
        end else if (en) begin
            if (last_ph) begin
                // Blanked pixels still strobe so the counter and colour stage
                // stay in step, but they carry no hits.
                hit_vec   <= display_on ? merged : '0;
                hit_any   <= display_on & (|merged);
                out_valid <= 1'b1;
                phase     <= '0;
                acc       <= '0;
                if (pix_cnt != {CNT_W{1'b1}})
                    pix_cnt <= pix_cnt + CNT_W'(1);
            end else begin
                // Phase 0 starts a fresh pixel, independent of what acc holds.
                acc       <= ((phase == '0) ? '0 : acc) | hit_in;
                phase     <= phase + PH_W'(1);
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shape_phase_sched.sv
// Bench for shape_phase_sched. Instance A uses the default parameters
// (2 phases, 21-bit hits, 10-bit counter); instance B uses 3 phases and a
// 3-bit counter for the rate/saturation/async-reset checks. Expected emits
// are pushed to a scoreboard queue when the emit cycle is driven and popped
// when out_valid appears.
module tb_shape_phase_sched;

    localparam int HW = 21;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic          reset, en, line_start, display_on;
    logic [HW-1:0] hit_in;
    logic [0:0]    phase;
    logic [HW-1:0] hit_vec;
    logic          hit_any, out_valid;
    logic [9:0]    pix_cnt;

    // instance B
    logic          rst_b, en_b, ls_b, disp_b;
    logic [HW-1:0] hit_b;
    logic [1:0]    phase_b;
    logic [HW-1:0] hv_b;
    logic          any_b, ov_b;
    logic [2:0]    cnt_b;

    shape_phase_sched #(.NUM_PHASES(2), .HIT_W(HW), .CNT_W(10)) dut_a (
        .clk(clk), .reset(reset), .en(en), .line_start(line_start),
        .display_on(display_on), .hit_in(hit_in), .phase(phase),
        .hit_vec(hit_vec), .hit_any(hit_any), .out_valid(out_valid),
        .pix_cnt(pix_cnt)
    );

    shape_phase_sched #(.NUM_PHASES(3), .HIT_W(HW), .CNT_W(3)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .line_start(ls_b),
        .display_on(disp_b), .hit_in(hit_b), .phase(phase_b),
        .hit_vec(hv_b), .hit_any(any_b), .out_valid(ov_b),
        .pix_cnt(cnt_b)
    );

    int vec  = 0;
    int miss = 0;

    // reference state for instance A
    int            m_ph  = 0;
    logic [HW-1:0] m_acc = '0;
    logic [HW-1:0] m_hv  = '0;
    int            m_cnt = 0;
    logic [HW-1:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A: drive, update the reference, clock, compare.
    task automatic step(input logic e, input logic ls, input logic d, input logic [HW-1:0] h);
        logic          emit_exp;
        logic [HW-1:0] exp_hv;
        emit_exp   = 1'b0;
        en         = e;
        line_start = ls;
        display_on = d;
        hit_in     = h;
        if (ls) begin
            m_ph = 0; m_acc = '0; m_cnt = 0;
        end else if (e) begin
            if (m_ph == 1) begin
                sb.push_back(d ? (m_acc | h) : '0);
                m_ph = 0; m_acc = '0; emit_exp = 1'b1;
                if (m_cnt != 1023) m_cnt++;
            end else begin
                m_acc = h;
                m_ph  = 1;
            end
        end
        @(posedge clk); #1;
        chk("out_valid", 64'(out_valid), 64'(emit_exp));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(0), 64'(1));
            end else begin
                exp_hv = sb.pop_front();
                m_hv   = exp_hv;
                chk("sb_hit_vec", 64'(hit_vec), 64'(exp_hv));
                chk("sb_hit_any", 64'(hit_any), 64'(|exp_hv));
            end
        end
        chk("hit_vec_hold", 64'(hit_vec), 64'(m_hv));
        chk("phase", 64'(phase), 64'(m_ph));
        chk("pix_cnt", 64'(pix_cnt), 64'(m_cnt));
    endtask

    initial begin
        int strobes;
        int cnt_before;
        reset = 1'b1; en = 1'b0; line_start = 1'b0; display_on = 1'b1; hit_in = '0;
        rst_b = 1'b1; en_b = 1'b0; ls_b = 1'b0; disp_b = 1'b1; hit_b = '0;
        #12;
        chk("rst_phase", 64'(phase), 0);
        chk("rst_hit_vec", 64'(hit_vec), 0);
        chk("rst_hit_any", 64'(hit_any), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_pix_cnt", 64'(pix_cnt), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // 1: idle, all-zero hits for 10 cycles -> 5 emits
        for (int i = 0; i < 10; i++) step(1, 0, 1, '0);
        chk("t1_pix_cnt", 64'(pix_cnt), 5);
        chk("t1_hit_any", 64'(hit_any), 0);

        // 2: merge across phases, then a clean pixel proves the clear
        step(1, 0, 1, 21'h000180);
        step(1, 0, 1, 21'h000001);
        chk("t2_hit_vec", 64'(hit_vec), 64'(21'h000181));
        chk("t2_hit_any", 64'(hit_any), 1);
        step(1, 0, 1, '0);
        step(1, 0, 1, '0);
        chk("t2_cleared", 64'(hit_vec), 0);

        // 3: blanking at the emit edge
        cnt_before = int'(pix_cnt);
        step(1, 0, 1, 21'h1FFFFF);
        step(1, 0, 0, 21'h1FFFFF);
        chk("t3_valid", 64'(out_valid), 1);
        chk("t3_hit_vec", 64'(hit_vec), 0);
        chk("t3_hit_any", 64'(hit_any), 0);
        chk("t3_pix_cnt", 64'(pix_cnt), 64'(cnt_before + 1));
        // display_on only matters at the emit edge
        step(1, 0, 0, 21'h000002);
        step(1, 0, 1, 21'h000008);
        chk("t3_late_disp", 64'(hit_vec), 64'(21'h00000A));

        // 4: stall in phase 1; hits during stall are ignored
        step(1, 0, 1, 21'h000004);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 21'h1FFFFF);
            chk("t4_stall_phase", 64'(phase), 1);
        end
        step(1, 0, 1, 21'h000010);
        chk("t4_hit_vec", 64'(hit_vec), 64'(21'h000014));

        // 5: line resync mid-pixel drops the partial pixel
        step(1, 0, 1, 21'h000007);
        step(1, 1, 1, 21'h000100);
        chk("t5_phase", 64'(phase), 0);
        chk("t5_pix_cnt", 64'(pix_cnt), 0);
        chk("t5_no_valid", 64'(out_valid), 0);
        step(1, 0, 1, 21'h000020);
        step(1, 0, 1, 21'h000001);
        chk("t5_hit_vec", 64'(hit_vec), 64'(21'h000021));
        // line_start wins even with en low
        step(1, 0, 1, 21'h000040);
        step(0, 1, 1, 21'h000040);
        chk("t5_ls_no_en", 64'(phase), 0);
        chk("sb_drained", 64'(sb.size()), 0);

        // 6: three phases, 3-bit counter saturates
        en = 1'b0;
        @(negedge clk);
        rst_b = 1'b0; en_b = 1'b1; disp_b = 1'b1; hit_b = 21'h000005;
        strobes = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (ov_b) strobes++;
            chk("t6_phase", 64'(phase_b), 64'(i % 3));
            chk("t6_valid", 64'(ov_b), 64'(i % 3 == 0));
            chk("t6_cnt", 64'(cnt_b), 64'(((i / 3) > 7) ? 7 : (i / 3)));
        end
        chk("t6_strobes", 64'(strobes), 10);
        chk("t6_hit_vec", 64'(hv_b), 64'(21'h000005));
        @(posedge clk); #1;
        chk("t6_mid_phase", 64'(phase_b), 1);
        // asynchronous reset between edges
        #2 rst_b = 1'b1;
        #1;
        chk("t6_ar_phase", 64'(phase_b), 0);
        chk("t6_ar_hit_vec", 64'(hv_b), 0);
        chk("t6_ar_hit_any", 64'(any_b), 0);
        chk("t6_ar_valid", 64'(ov_b), 0);
        chk("t6_ar_cnt", 64'(cnt_b), 0);
        @(negedge clk); rst_b = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("t6_post_rst_valid", 64'(ov_b), 64'(i == 3));
        end
        chk("t6_post_rst_hv", 64'(hv_b), 64'(21'h000005));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
